// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Brief    : Modulo-N up/down counter with synchronous parallel load,
//            combinational terminal-count output for cascading and a
//            registered one-cycle wrap-event pulse.
//
// Parameters
//   WIDTH      : counter width in bits (1..32)
//   MODULUS    : count range 0..MODULUS-1 (2..2^WIDTH)
//   RESET_VAL  : value loaded by reset (0..MODULUS-1)
//
// Ports
//   clk   in   1      sole clock, rising edge
//   res   in   1      synchronous active-high reset
//   en    in   1      count enable
//   up    in   1      direction: 1 = increment, 0 = decrement
//   load  in   1      synchronous parallel load strobe (beats en)
//   d     in   WIDTH  parallel load value, clamped to MODULUS-1
//   q     out  WIDTH  registered count value
//   tc    out  1      terminal count: en & (up ? q==MODULUS-1 : q==0)
//   wrap  out  1      registered pulse, high the cycle after a wrap
//
// Build options
//   COUNTER_SATURATE_EN : when defined, the counter holds at its end
//                         value instead of wrapping and wrap stays 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
    parameter int unsigned      WIDTH     = 4,
    parameter longint unsigned  MODULUS   = 16,
    parameter int unsigned      RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // MODULUS may be 2^WIDTH, so the top count is derived in 64-bit
    // arithmetic before being narrowed to the counter width.
    localparam logic [WIDTH-1:0] c_max   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero  = '0;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_load_val;

    assign w_at_max = (r_q == c_max);
    assign w_at_min = (r_q == c_zero);

    // Out-of-range load values clamp to the top of the count range so q
    // can never leave 0..MODULUS-1.
    assign w_load_val = (d > c_max) ? c_max : d;

    // Terminal count is purely a function of en, up and the current count;
    // load and res are deliberately excluded so a cascaded stage sees the
    // same tc regardless of what this stage does on the coming edge.
    assign tc = en & ((up & w_at_max) | (~up & w_at_min));

    // Next-state: load beats count; reset is applied in the register stage
    // and beats both.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_q_next = w_load_val;
        end else if (en) begin
            if (up) begin
                if (w_at_max) begin
`ifdef COUNTER_SATURATE_EN
                    w_q_next    = c_max;
`else
                    w_q_next    = c_zero;
                    w_wrap_next = 1'b1;
`endif
                end else begin
                    w_q_next = r_q + c_one;
                end
            end else begin
                if (w_at_min) begin
`ifdef COUNTER_SATURATE_EN
                    w_q_next    = c_zero;
`else
                    w_q_next    = c_max;
                    w_wrap_next = 1'b1;
`endif
                end else begin
                    w_q_next = r_q - c_one;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_q    <= c_reset;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updown_counter
// Brief    : Directed, table-driven bench for param_updown_counter.
//            Main instance: WIDTH=4, MODULUS=10, RESET_VAL=0.
//            Second instance: WIDTH=3, MODULUS=8, RESET_VAL=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    logic       clk;
    logic       res, en, up, load;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, wrap;

    logic       res2, en2, up2, load2;
    logic [2:0] d2;
    logic [2:0] q2;
    logic       tc2, wrap2;

    int checks;
    int errors;

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut (
        .clk(clk), .res(res), .en(en), .up(up), .load(load), .d(d),
        .q(q), .tc(tc), .wrap(wrap)
    );

    param_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) u_dut2 (
        .clk(clk), .res(res2), .en(en2), .up(up2), .load(load2), .d(d2),
        .q(q2), .tc(tc2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       res;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] d;
        logic       chk_tc;    // tc compared before the edge
        logic       exp_tc;
        logic [3:0] exp_q;     // q and wrap compared after the edge
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic l, logic e,
                                logic u, logic [3:0] dv, logic ct,
                                logic et, logic [3:0] eq, logic ew);
        vec_t v;
        v.name = name; v.res = r; v.load = l; v.en = e; v.up = u; v.d = dv;
        v.chk_tc = ct; v.exp_tc = et; v.exp_q = eq; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        res = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; d = '0;
        res2 = 1'b1; en2 = 1'b0; up2 = 1'b0; load2 = 1'b0; d2 = '0;
        checks = 0; errors = 0;

`ifndef COUNTER_SATURATE_EN
        //              name       res l e u d   ctc tc q  wrap
        vecs.push_back(mk("reset",  1, 1,1,1, 5,  0, 0, 0, 0));
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk("up_seq", 0, 0,1,1, 0, 1, (i == 9),
                              4'((i + 1) % 10), (i == 9)));
        vecs.push_back(mk("load3",  0, 1,0,0, 3,  1, 0, 3, 0));
        vecs.push_back(mk("dn3",    0, 0,1,0, 0,  1, 0, 2, 0));
        vecs.push_back(mk("dn2",    0, 0,1,0, 0,  1, 0, 1, 0));
        vecs.push_back(mk("dn1",    0, 0,1,0, 0,  1, 0, 0, 0));
        vecs.push_back(mk("dn0wrap",0, 0,1,0, 0,  1, 1, 9, 1));
        vecs.push_back(mk("dn9",    0, 0,1,0, 0,  1, 0, 8, 0));
        vecs.push_back(mk("ld12en", 0, 1,1,1,12,  1, 0, 9, 0));
        vecs.push_back(mk("ld_tc",  0, 1,1,1, 4,  1, 1, 4, 0));
        vecs.push_back(mk("hold",   0, 0,0,1, 0,  1, 0, 4, 0));
        vecs.push_back(mk("ld10",   0, 1,0,0,10,  1, 0, 9, 0));
        vecs.push_back(mk("ld15",   0, 1,0,0,15,  1, 0, 9, 0));
        vecs.push_back(mk("ld9",    0, 1,0,0, 9,  1, 0, 9, 0));
        vecs.push_back(mk("upwrap", 0, 0,1,1, 0,  1, 1, 0, 1));
        vecs.push_back(mk("wrapclr",0, 0,0,1, 0,  1, 0, 0, 0));
        vecs.push_back(mk("ld9b",   0, 1,0,0, 9,  1, 0, 9, 0));
        vecs.push_back(mk("dir_dn", 0, 0,1,0, 0,  1, 0, 8, 0));
        vecs.push_back(mk("dir_up", 0, 0,1,1, 0,  1, 0, 9, 0));
        vecs.push_back(mk("dir_dn2",0, 0,1,0, 0,  1, 0, 8, 0));
        vecs.push_back(mk("ld6",    0, 1,0,1, 6,  1, 0, 6, 0));
        vecs.push_back(mk("up7",    0, 0,1,1, 0,  1, 0, 7, 0));
        vecs.push_back(mk("resld",  1, 1,1,1, 5,  1, 0, 0, 0));
        vecs.push_back(mk("ld9c",   0, 1,0,1, 9,  1, 0, 9, 0));
        vecs.push_back(mk("res_abt",1, 0,1,1, 0,  1, 1, 0, 0));
        vecs.push_back(mk("post_rs",0, 0,1,1, 0,  1, 0, 1, 0));
        vecs.push_back(mk("ld7",    0, 1,0,1, 7,  1, 0, 7, 0));
`else
        vecs.push_back(mk("reset",  1, 0,0,1, 0,  0, 0, 0, 0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk("sat_up", 0, 0,1,1, 0, 1, 0, 4'(i + 1), 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("sat_hold", 0, 0,1,1, 0, 1, 1, 9, 0));
        vecs.push_back(mk("sat_dn", 0, 0,1,0, 0,  1, 0, 8, 0));
        vecs.push_back(mk("ld0",    0, 1,0,0, 0,  1, 0, 0, 0));
        vecs.push_back(mk("sat_lo", 0, 0,1,0, 0,  1, 1, 0, 0));
        vecs.push_back(mk("ld7",    0, 1,0,1, 7,  1, 0, 7, 0));
`endif

        @(negedge clk);
        foreach (vecs[i]) begin
            res = vecs[i].res; load = vecs[i].load; en = vecs[i].en;
            up = vecs[i].up; d = vecs[i].d;
            #1;
            if (vecs[i].chk_tc)
                chk({vecs[i].name, "/tc"}, int'(tc), int'(vecs[i].exp_tc));
            @(posedge clk); #1;
            chk({vecs[i].name, "/q"}, int'(q), int'(vecs[i].exp_q));
            chk({vecs[i].name, "/wrap"}, int'(wrap), int'(vecs[i].exp_wrap));
            @(negedge clk);
        end

        // Reset raised between edges must not touch q until the next edge
        // (q is 7 from the last vector).
        load = 1'b0; en = 1'b0;
        #1 res = 1'b1;
        #1 chk("res_mid/q_now", int'(q), 7);
        #2 chk("res_mid/q_late", int'(q), 7);
        @(posedge clk); #1;
        chk("res_mid/q_edge", int'(q), 0);
        @(negedge clk);
        res = 1'b0;

        // Second instance: reset to 5, then count up four times.
        res2 = 1'b1;
        @(posedge clk); #1;
        chk("m8_reset/q", int'(q2), 5);
        chk("m8_reset/wrap", int'(wrap2), 0);
        @(negedge clk);
        res2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int exp_q2;
            int exp_w2;
`ifndef COUNTER_SATURATE_EN
            exp_q2 = (6 + i) % 8;
            exp_w2 = (i == 2) ? 1 : 0;
`else
            exp_q2 = (6 + i > 7) ? 7 : 6 + i;
            exp_w2 = 0;
`endif
            @(posedge clk); #1;
            chk($sformatf("m8_up%0d/q", i), int'(q2), exp_q2);
            chk($sformatf("m8_up%0d/wrap", i), int'(wrap2), exp_w2);
            @(negedge clk);
        end
        en2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 1..32).
REQ-002 SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1 (legal range 2..2^WIDTH).
REQ-003 SHALL have parameter RESET_VAL, default 0, value loaded on reset (legal range 0..MODULUS-1).
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-005 SHALL have port res, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, count enable.
REQ-007 SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-009 SHALL have port d, input, WIDTH, parallel load value.
REQ-010 SHALL have port q, output, WIDTH, registered count value.
REQ-011 SHALL have port tc, output, 1, combinational terminal-count indication for cascading.
REQ-012 SHALL have port wrap, output, 1, registered one-cycle wrap-event pulse.

Function
REQ-013 Per-edge priority SHALL be res > load > en; with none of them active, q and wrap SHALL hold their values, except that wrap SHALL clear.
REQ-014 load=1: q SHALL take d next cycle.
REQ-015 load=1 with d >= MODULUS: q SHALL take MODULUS-1 (clamp).
REQ-016 load=1: wrap SHALL be 0 next cycle, regardless of en.
REQ-017 en=1, up=1, q < MODULUS-1: q SHALL take q+1 next cycle.
REQ-018 en=1, up=1, q = MODULUS-1: q SHALL take 0 next cycle.
REQ-019 en=1, up=0, q > 0: q SHALL take q-1 next cycle.
REQ-020 en=1, up=0, q = 0: q SHALL take MODULUS-1 next cycle.
REQ-021 wrap SHALL be 1 for exactly the one cycle following an edge where REQ-018 or REQ-020 applied, and 0 otherwise.
REQ-022 tc SHALL equal en AND ((up AND q=MODULUS-1) OR (NOT up AND q=0)), combinationally, with no dependence on load or res.
REQ-023 Count latency SHALL be one clock from en sampled high to q update, with no bubble between consecutive counts.
REQ-024 A direction change on up SHALL take effect on the same edge it is sampled, with no extra cycle.
REQ-025 All arithmetic SHALL be WIDTH bits wide; q SHALL never hold a value >= MODULUS after reset.
REQ-026 For MODULUS = 2^WIDTH, behaviour SHALL equal natural binary wrap.

Reset
REQ-027 res=1 at a rising clk edge SHALL set q to RESET_VAL and wrap to 0, regardless of load, en and up.
REQ-028 Reset SHALL have no asynchronous path; asserting res between edges SHALL leave q unchanged until the next edge.
REQ-029 Reset asserted mid-count SHALL abort the count with no wrap pulse; the first count after deassertion SHALL start from RESET_VAL.

Configuration
REQ-030 Macro COUNTER_SATURATE_EN SHALL select saturating mode.
REQ-031 With COUNTER_SATURATE_EN defined, REQ-018 and REQ-020 SHALL be replaced by hold: q SHALL stay at MODULUS-1 (up) or 0 (down).
REQ-032 With COUNTER_SATURATE_EN defined, wrap SHALL be tied to 0, and tc SHALL behave per REQ-022.
REQ-033 Without COUNTER_SATURATE_EN, wrapping behaviour per REQ-018 to REQ-021 SHALL apply.

Verification (WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated)
REQ-034 res 1 cycle, then en=1 and up=1 for 12 cycles -> q sequence 1..9,0,1,2; wrap high only in the cycle where q=0; tc high while q=9.
REQ-035 load with d=3, then en=1 and up=0 for 5 cycles -> q sequence 3,2,1,0,9,8; wrap pulses once with q=9; tc high while q=0.
REQ-036 load=1 with d=12 and en=1 on the same edge -> q=9, wrap=0; no count on that edge.
REQ-037 Counting up at q=7, res=1 and load=1 (d=5) on the same edge -> q=0, wrap=0; res asserted between edges -> q unchanged until the next edge.
REQ-038 COUNTER_SATURATE_EN defined, up to q=9, then 3 more en cycles -> q stays 9, wrap stays 0, tc=1; then up=0 -> q=8.
REQ-039 WIDTH=3, MODULUS=8, RESET_VAL=5: reset, then count up 4 cycles -> q sequence 6,7,0,1; wrap pulses once.
